// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the bit-serial sequence
// detector. It takes WIDTH-bit words on a valid/ready handshake and shifts
// them out on x, one bit per clk. A one-word hold buffer lets consecutive
// words stream with no gap bits between them.
// Build option: define SER_LSB_FIRST_EN to shift LSB first (default MSB first).
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             busy,
    output logic             word_done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hb_q, hb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sr_shifted;

    // All outputs decode from registers only; nothing from din/din_valid reaches x.
    assign din_ready = !hold_full_q;
    assign busy      = (state_q == SHIFT);
    assign last_bit  = busy && (cnt_q == LAST);
    assign word_done = last_bit;
    assign accept    = din_valid && din_ready;

`ifdef SER_LSB_FIRST_EN
    assign sr_shifted = sr_q >> 1;
    assign x          = busy ? sr_q[0] : IDLE_BIT;
`else
    assign sr_shifted = sr_q << 1;
    assign x          = busy ? sr_q[WIDTH-1] : IDLE_BIT;
`endif

    // Next-state: load, shift, hold-buffer capture and end-of-word resolution.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        hb_d        = hb_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sr_d  = sr_shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        hb_d        = din;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    // Held word has priority; din_ready is low then, so no accept can collide.
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sr_d        = hb_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sr_d = din;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset discarding any in-flight words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            hb_q        <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            hb_q        <= hb_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Testbench for seq_serializer. The reference model is a queue of bits still
// owed on x: an accepted word appends its WIDTH bits, every clock retires one.
module tb_seq_serializer;

    localparam int   W  = 8;
    localparam logic IB = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         x;
    logic         busy;
    logic         word_done;

    int n_tests = 0;
    int n_fail  = 0;

    bit mq[$];
    bit last_acc;

    seq_serializer #(.WIDTH(W), .IDLE_BIT(IB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // Order in which a word's bits appear on x.
    function automatic logic [W-1:0] stream_of(input logic [W-1:0] w);
        logic [W-1:0] r;
`ifdef SER_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[W-1-i] = w[i];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("x",         x,         (n > 0) ? logic'(mq[0]) : IB);
        chk("busy",      busy,      n > 0);
        chk("word_done", word_done, (n > 0) && (n % W == 1));
        chk("din_ready", din_ready, n <= W);
    endtask

    task automatic model_edge();
        bit acc;
        logic [W-1:0] s;
        acc = din_valid && (mq.size() <= W);
        if (mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
            s = stream_of(din);
            for (int i = W - 1; i >= 0; i--) mq.push_back(s[i]);
        end
        last_acc = acc;
    endtask

    task automatic cycle_get(output logic b);
        @(negedge clk);
        check_all();
        b = x;
        @(posedge clk);
        if (rst) model_edge();
        else begin
            mq.delete();
            last_acc = 1'b0;
        end
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] w, input string tag);
        logic        b;
        logic [31:0] s;
        s = '0;
        din = w;
        din_valid = 1'b1;
        cycle_get(b);
        din_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            cycle_get(b);
            s = {s[30:0], b};
        end
        chk_v(tag, s, {24'h0, stream_of(w)});
        cycle_get(b);
        chk(tag, x, IB);
    endtask

    task automatic run_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2, output logic [31:0] s,
                             output int nbits);
        logic [W-1:0] w[3];
        int  idx;
        bit  was_busy;
        logic b;
        w = '{w0, w1, w2};
        idx = 0;
        s = '0;
        nbits = 0;
        for (int c = 0; c < 200 && (idx < 3 || mq.size() > 0); c++) begin
            din_valid = (idx < 3);
            if (idx < 3) din = w[idx];
            was_busy = mq.size() > 0;
            cycle_get(b);
            if (was_busy) begin
                s = {s[30:0], b};
                nbits++;
            end
            if (last_acc) idx++;
        end
        din_valid = 1'b0;
    endtask

    initial begin
        logic        b;
        logic [31:0] s;
        int          nb;

        // Reset held with din_valid asserted: idle outputs, nothing accepted.
        rst = 1'b0;
        din_valid = 1'b1;
        din = 8'h5A;
        last_acc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_x",     x,         IB);
            chk("rst_ready", din_ready, 1'b1);
            chk("rst_busy",  busy,      1'b0);
            chk("rst_wd",    word_done, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        din_valid = 1'b0;
        repeat (2) cycle_get(b);

        // Single word from idle.
        send_one(8'h66, "word_66");

        // Back-to-back words with din_valid held.
        s = '0;
        din = 8'hA5;
        din_valid = 1'b1;
        cycle_get(b);
        din = 8'h3C;
        cycle_get(b);
        s = {s[30:0], b};
        din_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle_get(b);
            s = {s[30:0], b};
        end
        chk_v("b2b_stream", s, {16'h0, stream_of(8'hA5), stream_of(8'h3C)});
        cycle_get(b);

        // Backpressure with three words.
        run_words(8'hC3, 8'h5E, 8'h81, s, nb);
        chk_v("bp_nbits",  32'(nb), 32'd24);
        chk_v("bp_stream", s, {8'h0, stream_of(8'hC3), stream_of(8'h5E), stream_of(8'h81)});
        cycle_get(b);

        // Reset on bit 3 of a word while the hold buffer is full.
        din = 8'hAA;
        din_valid = 1'b1;
        cycle_get(b);
        din = 8'h55;
        cycle_get(b);
        din_valid = 1'b0;
        chk("hb_full_ready", din_ready, 1'b0);
        cycle_get(b);
        cycle_get(b);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_x",     x,         IB);
        chk("mid_rst_busy",  busy,      1'b0);
        chk("mid_rst_ready", din_ready, 1'b1);
        chk("mid_rst_wd",    word_done, 1'b0);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_one(8'hFF, "post_rst_ff");
        repeat (3) cycle_get(b);

        // Bit-order checks for both builds.
        send_one(8'h66, "order_66");
        send_one(8'h01, "order_01");

        // Randomized traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            if (!(din_valid && !last_acc)) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = W'($urandom);
            end
            cycle_get(b);
        end
        din_valid = 1'b0;
        for (int c = 0; c < 3 * W && mq.size() > 0; c++) cycle_get(b);
        cycle_get(b);
        chk("drain_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
